// File: rtl/vga_fetch_sched_if.sv
// Bundle between the line-fetch scheduler, its line/frame timing source,
// the SDRAM read port and the line buffer.
interface vga_fetch_sched_if #(
    parameter int unsigned NUM_LAYERS = 4
);
    logic                     line_start;
    logic                     frame_start;
    logic [NUM_LAYERS-1:0]    layer_valid;
    logic [NUM_LAYERS*26-1:0] layer_addr;
    logic [NUM_LAYERS*11-1:0] layer_len;

    logic                     sdram_req;
    logic [25:0]              sdram_addr;
    logic                     sdram_ack;
    logic                     sdram_rvalid;
    logic [31:0]              sdram_rdata;

    logic                     lb_write;
    logic [2:0]               lb_layer;
    logic [8:0]               lb_addr;
    logic [31:0]              lb_wdata;

    logic                     busy;
    logic                     overrun;

    modport master (
        input  line_start, frame_start, layer_valid, layer_addr, layer_len,
        input  sdram_ack, sdram_rvalid, sdram_rdata,
        output sdram_req, sdram_addr,
        output lb_write, lb_layer, lb_addr, lb_wdata,
        output busy, overrun
    );

    modport slave (
        output line_start, frame_start, layer_valid, layer_addr, layer_len,
        output sdram_ack, sdram_rvalid, sdram_rdata,
        input  sdram_req, sdram_addr,
        input  lb_write, lb_layer, lb_addr, lb_wdata,
        input  busy, overrun
    );
endinterface

// File: rtl/vga_fetch_sched.sv
// Per-line SDRAM burst fetch scheduler: walks the pending display layers in
// index order and streams each layer's line into the line buffer.
module vga_fetch_sched #(
    parameter int unsigned NUM_LAYERS  = 4,
    parameter int unsigned BURST_WORDS = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    vga_fetch_sched_if.master bus
);
    localparam int unsigned AW     = 26;
    localparam int unsigned LW     = 11;
    localparam int unsigned BYTES  = 4 * BURST_WORDS;
    localparam int unsigned SHIFT  = $clog2(BYTES);
    localparam int unsigned BEAT_W = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;
    localparam int unsigned LIDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int unsigned BCNT_W = LW + 1;
    localparam logic [AW-1:0] WORD_MASK = ~AW'(3);

    typedef enum logic [2:0] {ST_IDLE, ST_SELECT, ST_REQ, ST_DATA, ST_DRAIN} state_e;

    state_e                state_q;
    logic [NUM_LAYERS-1:0] pending_q;
    logic [AW-1:0]         addr_q [NUM_LAYERS];
    logic [LW-1:0]         len_q  [NUM_LAYERS];
    logic [LIDX_W-1:0]     cur_q;
    logic [BCNT_W-1:0]     bursts_q;
    logic [BEAT_W-1:0]     beat_q;
    logic [8:0]            widx_q;

    logic                  sdram_req_q;
    logic [AW-1:0]         sdram_addr_q;
    logic                  lb_write_q;
    logic [2:0]            lb_layer_q;
    logic [8:0]            lb_addr_q;
    logic [31:0]           lb_wdata_q;
    logic                  busy_q;
    logic                  overrun_q;

    logic [LIDX_W-1:0]     sel_c;
    logic                  any_c;
    logic [BCNT_W-1:0]     sel_bursts_c;
    logic                  last_beat_c;

    // Lowest-index pending layer wins.
    always_comb begin
        sel_c = '0;
        any_c = 1'b0;
        for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel_c = LIDX_W'(i);
                any_c = 1'b1;
            end
        end
    end

    assign sel_bursts_c = BCNT_W'((32'(len_q[sel_c]) + 32'(BYTES - 1)) >> SHIFT);
    assign last_beat_c  = (beat_q == BEAT_W'(BURST_WORDS - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            pending_q    <= '0;
            for (int i = 0; i < int'(NUM_LAYERS); i++) begin
                addr_q[i] <= '0;
                len_q[i]  <= '0;
            end
            cur_q        <= '0;
            bursts_q     <= '0;
            beat_q       <= '0;
            widx_q       <= '0;
            sdram_req_q  <= 1'b0;
            sdram_addr_q <= '0;
            lb_write_q   <= 1'b0;
            lb_layer_q   <= '0;
            lb_addr_q    <= '0;
            lb_wdata_q   <= '0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            lb_write_q <= 1'b0;
            // frame_start outranks a coincident line_start, so no overrun then.
            overrun_q  <= bus.line_start && !bus.frame_start && busy_q;

            case (state_q)
                ST_IDLE: begin
                    if (bus.line_start && !bus.frame_start) begin
                        for (int i = 0; i < int'(NUM_LAYERS); i++) begin
                            addr_q[i]    <= bus.layer_addr[i*AW +: AW] & WORD_MASK;
                            len_q[i]     <= bus.layer_len[i*LW +: LW];
                            pending_q[i] <= bus.layer_valid[i] && (bus.layer_len[i*LW +: LW] != '0);
                        end
                        state_q <= ST_SELECT;
                        busy_q  <= 1'b1;
                    end
                end

                ST_SELECT: begin
                    if (bus.frame_start || !any_c) begin
                        pending_q <= '0;
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                    end else begin
                        cur_q        <= sel_c;
                        bursts_q     <= sel_bursts_c;
                        widx_q       <= '0;
                        sdram_addr_q <= addr_q[sel_c];
                        sdram_req_q  <= 1'b1;
                        state_q      <= ST_REQ;
                    end
                end

                ST_REQ: begin
                    // An abort racing the ack still owes us a burst, so drain it.
                    if (bus.sdram_ack) begin
                        sdram_req_q <= 1'b0;
                        beat_q      <= '0;
                        if (bus.frame_start) begin
                            pending_q <= '0;
                            state_q   <= ST_DRAIN;
                        end else begin
                            state_q   <= ST_DATA;
                        end
                    end else if (bus.frame_start) begin
                        sdram_req_q <= 1'b0;
                        pending_q   <= '0;
                        state_q     <= ST_IDLE;
                        busy_q      <= 1'b0;
                    end
                end

                ST_DATA: begin
                    if (bus.sdram_rvalid) begin
                        beat_q <= beat_q + BEAT_W'(1);
                        if (!bus.frame_start) begin
                            lb_write_q <= 1'b1;
                            lb_layer_q <= 3'(cur_q);
                            lb_addr_q  <= widx_q;
                            lb_wdata_q <= bus.sdram_rdata;
                            widx_q     <= widx_q + 9'd1;
                        end
                    end
                    if (bus.frame_start) begin
                        pending_q <= '0;
                        if (bus.sdram_rvalid && last_beat_c) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_DRAIN;
                        end
                    end else if (bus.sdram_rvalid && last_beat_c) begin
                        if (bursts_q != BCNT_W'(1)) begin
                            bursts_q     <= bursts_q - BCNT_W'(1);
                            sdram_addr_q <= sdram_addr_q + AW'(BYTES);
                            sdram_req_q  <= 1'b1;
                            state_q      <= ST_REQ;
                        end else begin
                            pending_q[cur_q] <= 1'b0;
                            state_q          <= ST_SELECT;
                        end
                    end
                end

                ST_DRAIN: begin
                    if (bus.sdram_rvalid) begin
                        beat_q <= beat_q + BEAT_W'(1);
                        if (last_beat_c) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sdram_req  = sdram_req_q;
    assign bus.sdram_addr = sdram_addr_q;
    assign bus.lb_write   = lb_write_q;
    assign bus.lb_layer   = lb_layer_q;
    assign bus.lb_addr    = lb_addr_q;
    assign bus.lb_wdata   = lb_wdata_q;
    assign bus.busy       = busy_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_vga_fetch_sched.sv
// Bench for vga_fetch_sched: SDRAM responder plus line-buffer scoreboard,
// a descriptor table for whole-line fetches and hand sequences for aborts.
module tb_vga_fetch_sched;
    localparam int NL = 4;
    localparam int BW = 16;

    typedef struct {
        logic [3:0]       valid;
        logic [3:0][25:0] addr;
        logic [3:0][10:0] len;
        int               exp_req;
        int               exp_wr;
    } vec_t;

    typedef struct {
        logic [25:0] addr;
        logic [2:0]  layer;
        logic [8:0]  widx;
    } req_t;

    typedef struct {
        logic [2:0]  layer;
        logic [8:0]  idx;
        logic [31:0] data;
    } wr_t;

    logic clock;
    logic rst_n;

    vga_fetch_sched_if #(.NUM_LAYERS(NL)) bus ();

    vga_fetch_sched #(.NUM_LAYERS(NL), .BURST_WORDS(BW)) dut (
        .clock   (clock),
        .reset_n (rst_n),
        .bus     (bus)
    );

    req_t        req_q[$];
    wr_t         wr_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          n_req = 0;
    int          n_wr  = 0;
    int          n_ovr = 0;
    int          beats_left = 0;
    int          beat_no = 0;
    logic [25:0] burst_addr = '0;
    bit          model_en = 1'b1;
    bit          stray_rv = 1'b0;
    req_t        mdl_r;
    wr_t         mon_w;

    initial begin
        clock = 1'b0;
        forever #4 clock = ~clock;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] data_of(input logic [25:0] a, input int b);
        return {6'(b), a} ^ 32'h5a5a_0000;
    endfunction

    // Expected burst sequence for a descriptor set, in layer-index order.
    function automatic void plan(input vec_t v);
        int          nb;
        logic [25:0] base;
        for (int i = 0; i < NL; i++) begin
            if (v.valid[i] && v.len[i] != 11'd0) begin
                nb   = (int'(v.len[i]) + 4*BW - 1) / (4*BW);
                base = v.addr[i] & ~26'h3;
                for (int k = 0; k < nb; k++)
                    req_q.push_back('{addr: base + 26'(k*4*BW), layer: 3'(i), widx: 9'(k*BW)});
            end
        end
    endfunction

    task automatic drive_desc(input vec_t v);
        bus.layer_valid = v.valid;
        bus.layer_addr  = v.addr;
        bus.layer_len   = v.len;
    endtask

    task automatic pulse_line();
        bus.line_start = 1'b1;
        @(negedge clock); #1;
        bus.line_start = 1'b0;
        bus.layer_valid = 4'($urandom());
        bus.layer_addr  = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.layer_len   = {$urandom(), $urandom()};
    endtask

    task automatic wait_idle();
        int c = 0;
        while (bus.busy === 1'b1 && c < 20000) begin
            @(negedge clock); #1;
            c++;
        end
    endtask

    task automatic clear_counts();
        n_req = 0;
        n_wr  = 0;
        n_ovr = 0;
    endtask

    // SDRAM responder: random ack latency and beat gaps; one burst at a time.
    initial begin
        bus.sdram_ack    = 1'b0;
        bus.sdram_rvalid = 1'b0;
        bus.sdram_rdata  = '0;
        forever begin
            @(negedge clock);
            bus.sdram_ack    = 1'b0;
            bus.sdram_rvalid = stray_rv;
            bus.sdram_rdata  = $urandom();
            if (!rst_n) begin
                beats_left = 0;
            end else if (beats_left > 0) begin
                if ($urandom_range(0, 3) != 0) begin
                    bus.sdram_rvalid = 1'b1;
                    bus.sdram_rdata  = data_of(burst_addr, beat_no);
                    beat_no++;
                    beats_left--;
                end
            end else if (model_en && bus.sdram_req === 1'b1 && $urandom_range(0, 1) == 0) begin
                bus.sdram_ack = 1'b1;
                burst_addr    = bus.sdram_addr;
                beats_left    = BW;
                beat_no       = 0;
                n_req++;
                if (req_q.size() == 0) begin
                    chk("sdram_req_unexpected", 64'(bus.sdram_req), 64'(0));
                end else begin
                    mdl_r = req_q.pop_front();
                    chk("sdram_addr", 64'(bus.sdram_addr), 64'(mdl_r.addr));
                    for (int w = 0; w < BW; w++)
                        wr_q.push_back('{layer: mdl_r.layer, idx: mdl_r.widx + 9'(w),
                                         data: data_of(mdl_r.addr, w)});
                end
            end
        end
    end

    // Line-buffer monitor: every write must match the scoreboard head.
    always @(negedge clock) begin
        if (bus.lb_write === 1'b1) begin
            n_wr++;
            if (wr_q.size() == 0) begin
                chk("lb_write_unexpected", 64'(bus.lb_write), 64'(0));
            end else begin
                mon_w = wr_q.pop_front();
                chk("lb_layer", 64'(bus.lb_layer), 64'(mon_w.layer));
                chk("lb_addr",  64'(bus.lb_addr),  64'(mon_w.idx));
                chk("lb_wdata", 64'(bus.lb_wdata), 64'(mon_w.data));
            end
        end
        if (bus.overrun === 1'b1) n_ovr++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[8];
        vec_t hv;
        int   c;

        vt[0] = '{valid: 4'b0001, addr: {26'h0, 26'h0, 26'h0, 26'h3f80000},
                  len: {11'd0, 11'd0, 11'd0, 11'd640}, exp_req: 10, exp_wr: 160};
        vt[1] = '{valid: 4'b0111, addr: {26'h0004000, 26'h0003000, 26'h0002000, 26'h0001000},
                  len: {11'd64, 11'd64, 11'd0, 11'd64}, exp_req: 2, exp_wr: 32};
        vt[2] = '{valid: 4'b0001, addr: {26'h0, 26'h0, 26'h0, 26'h0100000},
                  len: {11'd0, 11'd0, 11'd0, 11'd100}, exp_req: 2, exp_wr: 32};
        vt[3] = '{valid: 4'b0001, addr: {26'h0, 26'h0, 26'h0, 26'h0000103},
                  len: {11'd0, 11'd0, 11'd0, 11'd1}, exp_req: 1, exp_wr: 16};
        vt[4] = '{valid: 4'b1000, addr: {26'h3ffffc0, 26'h0, 26'h0, 26'h0},
                  len: {11'd128, 11'd0, 11'd0, 11'd0}, exp_req: 2, exp_wr: 32};
        vt[5] = '{valid: 4'b1010, addr: {26'h0300000, 26'h0, 26'h0200000, 26'h0},
                  len: {11'd65, 11'd100, 11'd2047, 11'd64}, exp_req: 34, exp_wr: 544};
        vt[6] = '{valid: 4'b0000, addr: {26'h10, 26'h20, 26'h30, 26'h40},
                  len: {11'd64, 11'd64, 11'd64, 11'd64}, exp_req: 0, exp_wr: 0};
        vt[7] = '{valid: 4'b1111, addr: {26'h0070008, 26'h0060000, 26'h0050004, 26'h0040000},
                  len: {11'd65, 11'd1000, 11'd64, 11'd192}, exp_req: 22, exp_wr: 352};

        bus.line_start  = 1'b0;
        bus.frame_start = 1'b0;
        bus.layer_valid = '0;
        bus.layer_addr  = '0;
        bus.layer_len   = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_sdram_req",  64'(bus.sdram_req),  64'(0));
        chk("rst_sdram_addr", 64'(bus.sdram_addr), 64'(0));
        chk("rst_lb_write",   64'(bus.lb_write),   64'(0));
        chk("rst_lb_layer",   64'(bus.lb_layer),   64'(0));
        chk("rst_lb_addr",    64'(bus.lb_addr),    64'(0));
        chk("rst_lb_wdata",   64'(bus.lb_wdata),   64'(0));
        chk("rst_busy",       64'(bus.busy),       64'(0));
        chk("rst_overrun",    64'(bus.overrun),    64'(0));
        repeat (2) @(negedge clock);
        #1 rst_n = 1'b1;
        @(negedge clock); #1;

        for (int t = 0; t < 8; t++) begin
            clear_counts();
            drive_desc(vt[t]);
            plan(vt[t]);
            pulse_line();
            wait_idle();
            chk($sformatf("v%0d_busy_idle", t), 64'(bus.busy), 64'(0));
            chk($sformatf("v%0d_req_left", t),  64'(req_q.size()), 64'(0));
            chk($sformatf("v%0d_wr_left", t),   64'(wr_q.size()),  64'(0));
            chk($sformatf("v%0d_n_req", t),     64'(n_req), 64'(vt[t].exp_req));
            chk($sformatf("v%0d_n_wr", t),      64'(n_wr),  64'(vt[t].exp_wr));
            chk($sformatf("v%0d_overrun", t),   64'(n_ovr), 64'(0));
            req_q.delete();
            wr_q.delete();
            repeat (3) @(negedge clock);
            #1;
        end

        // line_start during DATA: one overrun pulse, fetch undisturbed.
        clear_counts();
        hv = '{valid: 4'b0100, addr: {26'h0, 26'h0010000, 26'h0, 26'h0},
               len: {11'd0, 11'd192, 11'd0, 11'd0}, exp_req: 3, exp_wr: 48};
        drive_desc(hv);
        plan(hv);
        pulse_line();
        c = 0;
        while (n_wr < 3 && c < 500) begin @(negedge clock); #1; c++; end
        bus.line_start = 1'b1;
        @(negedge clock); #1;
        bus.line_start = 1'b0;
        chk("ovr_pulse_high", 64'(bus.overrun), 64'(1));
        @(negedge clock); #1;
        chk("ovr_pulse_low", 64'(bus.overrun), 64'(0));
        wait_idle();
        chk("ovr_busy_idle", 64'(bus.busy), 64'(0));
        chk("ovr_n_req", 64'(n_req), 64'(hv.exp_req));
        chk("ovr_n_wr",  64'(n_wr),  64'(hv.exp_wr));
        chk("ovr_count", 64'(n_ovr), 64'(1));
        chk("ovr_wr_left", 64'(wr_q.size()), 64'(0));
        repeat (3) @(negedge clock);
        #1;

        // frame_start (with a coincident line_start) after the 5th beat.
        clear_counts();
        hv = '{valid: 4'b0001, addr: {26'h0, 26'h0, 26'h0, 26'h0004000},
               len: {11'd0, 11'd0, 11'd0, 11'd640}, exp_req: 1, exp_wr: 5};
        drive_desc(hv);
        plan(hv);
        pulse_line();
        c = 0;
        while (n_wr < 5 && c < 500) begin @(negedge clock); #1; c++; end
        bus.frame_start = 1'b1;
        bus.line_start  = 1'b1;
        req_q.delete();
        wr_q.delete();
        @(negedge clock); #1;
        bus.frame_start = 1'b0;
        bus.line_start  = 1'b0;
        chk("abort_no_overrun", 64'(bus.overrun), 64'(0));
        chk("abort_busy_drain", 64'(bus.busy), 64'(1));
        wait_idle();
        chk("abort_busy_idle", 64'(bus.busy), 64'(0));
        chk("abort_beats_left_at_idle", 64'(beats_left), 64'(0));
        chk("abort_beats_at_idle", 64'(beat_no), 64'(BW));
        repeat (20) @(negedge clock);
        #1;
        chk("abort_no_new_req", 64'(bus.sdram_req), 64'(0));
        chk("abort_n_req", 64'(n_req), 64'(hv.exp_req));
        chk("abort_n_wr",  64'(n_wr),  64'(hv.exp_wr));

        // frame_start while a request is waiting for ack.
        clear_counts();
        model_en = 1'b0;
        hv = '{valid: 4'b0001, addr: {26'h0, 26'h0, 26'h0, 26'h0020000},
               len: {11'd0, 11'd0, 11'd0, 11'd64}, exp_req: 0, exp_wr: 0};
        drive_desc(hv);
        plan(hv);
        pulse_line();
        c = 0;
        while (bus.sdram_req !== 1'b1 && c < 50) begin @(negedge clock); #1; c++; end
        chk("reqabort_req_high", 64'(bus.sdram_req), 64'(1));
        chk("reqabort_addr", 64'(bus.sdram_addr), 64'(26'h0020000));
        repeat (3) @(negedge clock);
        #1;
        chk("reqabort_req_held", 64'(bus.sdram_req), 64'(1));
        bus.frame_start = 1'b1;
        @(negedge clock); #1;
        bus.frame_start = 1'b0;
        chk("reqabort_req_dropped", 64'(bus.sdram_req), 64'(0));
        chk("reqabort_busy", 64'(bus.busy), 64'(0));
        req_q.delete();
        model_en = 1'b1;
        repeat (10) @(negedge clock);
        #1;
        chk("reqabort_n_req", 64'(n_req), 64'(0));
        chk("reqabort_n_wr",  64'(n_wr),  64'(0));

        // Asynchronous reset while requesting, then stray beats.
        clear_counts();
        model_en = 1'b0;
        hv = '{valid: 4'b0001, addr: {26'h0, 26'h0, 26'h0, 26'h0030000},
               len: {11'd0, 11'd0, 11'd0, 11'd640}, exp_req: 0, exp_wr: 0};
        drive_desc(hv);
        plan(hv);
        pulse_line();
        c = 0;
        while (bus.sdram_req !== 1'b1 && c < 50) begin @(negedge clock); #1; c++; end
        chk("rst_mid_req_high", 64'(bus.sdram_req), 64'(1));
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_req", 64'(bus.sdram_req), 64'(0));
        chk("rst_mid_busy", 64'(bus.busy), 64'(0));
        chk("rst_mid_addr", 64'(bus.sdram_addr), 64'(0));
        @(negedge clock); #1;
        rst_n = 1'b1;
        req_q.delete();
        wr_q.delete();
        stray_rv = 1'b1;
        repeat (6) @(negedge clock);
        #1;
        stray_rv = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        chk("rst_stray_n_wr", 64'(n_wr), 64'(0));
        chk("rst_stray_busy", 64'(bus.busy), 64'(0));
        model_en = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/vga_fetch_sched.md
VGA_FETCH_SCHED -- requirements
Module: vga_fetch_sched

Interface
REQ-001 Parameter NUM_LAYERS, default 4, number of display layers served (1..8).
REQ-002 Parameter BURST_WORDS, default 16, 32-bit words per SDRAM burst (power of two).
REQ-003 clock  in  1  system clock, 125MHz; all logic on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 line_start  in  1  one-cycle pulse, start fetching the next display line.
REQ-006 frame_start  in  1  one-cycle pulse, abort any fetch in progress.
REQ-007 layer_valid  in  NUM_LAYERS  per-layer enable, sampled on accepted line_start.
REQ-008 layer_addr  in  NUM_LAYERS*26  per-layer byte address of line start, word aligned (bits 1:0 ignored).
REQ-009 layer_len  in  NUM_LAYERS*11  per-layer line length in bytes.
REQ-010 sdram_req  out  1  burst read request, held until sdram_ack.
REQ-011 sdram_addr  out  26  burst byte address, stable while sdram_req high.
REQ-012 sdram_ack  in  1  request accepted this cycle.
REQ-013 sdram_rvalid  in  1  read data beat valid; exactly BURST_WORDS beats per accepted request.
REQ-014 sdram_rdata  in  32  read data.
REQ-015 lb_write  out  1  line-buffer write strobe.
REQ-016 lb_layer  out  3  layer index of write.
REQ-017 lb_addr  out  9  word index within layer's line.
REQ-018 lb_wdata  out  32  write data.
REQ-019 busy  out  1  high in any state except IDLE.
REQ-020 overrun  out  1  one-cycle pulse, line_start arrived while busy.

Function
REQ-021 States IDLE, SELECT, REQ, DATA, DRAIN; one request outstanding at most.
REQ-022 IDLE: line_start latches all descriptors, pending[i]=layer_valid[i] && layer_len[i]!=0; next state SELECT.
REQ-023 SELECT: lowest-index pending layer chosen, bursts = ceil(layer_len/(4*BURST_WORDS)), word index cleared, next REQ; none pending -> IDLE.
REQ-024 REQ: sdram_req=1, sdram_addr=current burst address; sdram_ack -> DATA next cycle.
REQ-025 DATA: each sdram_rvalid produces lb_write=1 one cycle later with registered layer, word index, data; word index increments by 1 per beat.
REQ-026 After BURST_WORDS beats: bursts-1; if nonzero, address += 4*BURST_WORDS, REQ; else pending[i] cleared, SELECT.
REQ-027 Final burst always full length; words past layer_len still written (line buffer sized for it); word index wraps at 512.
REQ-028 Address arithmetic modulo 2^26.
REQ-029 line_start while busy: overrun pulses next cycle, line_start ignored, current fetch continues.
REQ-030 frame_start in SELECT or REQ: sdram_req dropped next cycle, pending cleared, IDLE.
REQ-031 frame_start in DATA: DRAIN; remaining beats of current burst consumed with lb_write held 0; then IDLE.
REQ-032 frame_start and line_start same cycle: frame_start wins, line_start ignored, no overrun.
REQ-033 sdram_rvalid outside DATA/DRAIN ignored.

Reset
REQ-034 reset_n low: state IDLE, pending=0, sdram_req=0, sdram_addr=0, lb_write=0, lb_layer=0, lb_addr=0, lb_wdata=0, busy=0, overrun=0, immediately and asynchronously.
REQ-035 reset_n asserted mid-burst: no further lb_write; beats arriving after release ignored per REQ-033.

Verification
REQ-036 Layer 0 valid, addr 0x3f80000, len 640; line_start -> 10 requests at 0x3f80000+64k, 160 lb_write to layer 0, lb_addr 0..159, then busy=0.
REQ-037 Layers 0 and 2 valid, len 64 each, layer 1 valid len 0 -> one burst layer 0 then one burst layer 2; layer 1 never requested.
REQ-038 layer_len 100 -> 2 bursts, 32 lb_write, lb_addr 0..31.
REQ-039 line_start during DATA -> overrun one cycle, fetch completes unchanged.
REQ-040 frame_start after 5th beat of a 16-beat burst -> no lb_write for remaining 11 beats, IDLE after 16th beat, no new sdram_req.
REQ-041 reset_n pulsed low while sdram_req high -> sdram_req and busy 0 immediately; stray rvalid after release causes no lb_write.
